// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide controller owning the HI/LO pair.
// Results are computed at issue and committed after a fixed latency.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        op_valid_i,
    input  logic [3:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        cancel_i,
    output logic        busy_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic [31:0] rd_data_o
);

    // state  | meaning
    // S_IDLE | accepts mult/div issue and MTHI/MTLO writes
    // S_RUN  | counting down to the HI/LO commit; requests ignored
    typedef enum logic {S_IDLE, S_RUN} state_t;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        dz_q, dz_d;

    logic        is_md;
    logic        req_ok;
    logic        b_zero;
    logic        div_ovf;
    logic [31:0] b_sdiv;
    logic [31:0] b_udiv;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] quot_s;
    logic [31:0] rem_s;
    logic [31:0] quot_u;
    logic [31:0] rem_u;

    assign is_md   = (op_i >= OP_MULT) && (op_i <= OP_DIVU);
    assign req_ok  = op_valid_i && !cancel_i;
    assign b_zero  = (b_i == 32'd0);
    assign div_ovf = (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);

    // Divisor forced to 1 for /0 (result discarded) and for the overflow case,
    // where a/1 already yields quotient 0x80000000 and remainder 0.
    assign b_sdiv = (b_zero || div_ovf) ? 32'd1 : b_i;
    assign b_udiv = b_zero ? 32'd1 : b_i;

    assign prod_s = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
    assign prod_u = {32'd0, a_i} * {32'd0, b_i};
    assign quot_s = $signed(a_i) / $signed(b_sdiv);
    assign rem_s  = $signed(a_i) % $signed(b_sdiv);
    assign quot_u = a_i / b_udiv;
    assign rem_u  = a_i % b_udiv;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            dz_q      <= dz_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        dz_d      = dz_q;
        case (state_q)
            S_IDLE: begin
                if (req_ok) begin
                    case (op_i)
                        OP_MULT: begin
                            {pend_hi_d, pend_lo_d} = prod_s;
                            cnt_d   = MULT_LOAD;
                            dz_d    = 1'b0;
                            state_d = S_RUN;
                        end
                        OP_MULTU: begin
                            {pend_hi_d, pend_lo_d} = prod_u;
                            cnt_d   = MULT_LOAD;
                            dz_d    = 1'b0;
                            state_d = S_RUN;
                        end
                        OP_DIV: begin
                            pend_hi_d = rem_s;
                            pend_lo_d = quot_s;
                            cnt_d     = DIV_LOAD;
                            dz_d      = b_zero;
                            state_d   = S_RUN;
                        end
                        OP_DIVU: begin
                            pend_hi_d = rem_u;
                            pend_lo_d = quot_u;
                            cnt_d     = DIV_LOAD;
                            dz_d      = b_zero;
                            state_d   = S_RUN;
                        end
                        OP_MTHI: hi_d = a_i;
                        OP_MTLO: lo_d = a_i;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                if (cnt_q == 4'd0) begin
                    if (!dz_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy_o = (op_valid_i && is_md) || (state_q == S_RUN);
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

    always_comb begin
        rd_data_o = 32'd0;
        case (op_i)
            OP_MFHI: rd_data_o = hi_q;
            OP_MFLO: rd_data_o = lo_q;
            default: ;
        endcase
    end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multi-cycle multiply/divide controller for the P7 pipeline's execute stage. It sits beside the ALU and owns the HI/LO register pair. It accepts MULT/MULTU/DIV/DIVU, MTHI/MTLO and MFHI/MFLO requests, and holds each multiply or divide for a fixed latency while `busy` stalls dependent instructions. An exception in the issuing cycle suppresses the request through `cancel`.

## Interface
- MULT_CYCLES, 5, cycles from a multiply's issue edge to its HI/LO commit edge (≥1)
- DIV_CYCLES, 10, cycles from a divide's issue edge to its HI/LO commit edge (≥1)

- clk  in  1  clock; all state updates on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- op_valid  in  1  request present this cycle
- op  in  4  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO; 9–15 are treated as none
- a  in  32  rs operand
- b  in  32  rt operand
- cancel  in  1  exception or flush this cycle; the request has no effect
- busy  out  1  op_valid & (op in 1..4) | running; combinational
- hi  out  32  HI register
- lo  out  32  LO register
- rd_data  out  32  combinational: hi when op==7, lo when op==8, else 0

## Operation
- State: `running` (1b), `cnt` (4b), `pend_hi`/`pend_lo` (32b each), `hi`, `lo`.
- **IDLE (`running`=0), issue condition:** op_valid & !cancel & op in 1..4.
  - Compute the result combinationally from `a` and `b` and latch it into pend_hi/pend_lo.
  - Load `cnt` with MULT_CYCLES−1 or DIV_CYCLES−1.
  - Set `running`.
- **Results:**
  - MULT: {pend_hi, pend_lo} = signed 64-bit product.
  - MULTU: same, unsigned.
  - DIV: pend_lo = quotient truncated toward zero; pend_hi = remainder with the sign of the dividend (a).
  - DIVU: unsigned quotient and remainder.
- **Divide by zero (b==0):** the full latency still runs; the commit leaves hi/lo unchanged.
- **Signed overflow:** DIV of 0x80000000 by 0xFFFFFFFF gives lo=0x80000000, hi=0.
- **RUNNING:** `cnt` decrements each edge. On the edge where cnt==0, hi/lo ← pending (unless divide-by-zero) and `running` clears.
- **MTHI/MTLO:** when op_valid & !cancel & !running, write `a` into hi or lo at the edge.
- **Requests while running:** any MTHI/MTLO or mult/div request is ignored. The hazard unit stalls on `busy`; a request that arrives anyway does not restart or corrupt the operation in flight.
- **MFHI/MFLO:** pure combinational reads with no state change. While running, rd_data returns the old (pre-commit) hi/lo; the hazard unit stalls these reads on `busy`.
- **cancel:** has no effect on an operation already running. It only masks the same-cycle request.
- **Reset (asynchronous, any time, including mid-operation):** running=0, cnt=0, hi=lo=pend_hi=pend_lo=0. Therefore busy=0 unless a request is on the inputs, and the operation in flight is discarded.

## Timing
- Cycle 0 is the issue cycle. `busy` is high in cycle 0 (combinational) and through cycle L, where L = MULT_CYCLES or DIV_CYCLES.
- Commit happens at the end of cycle L. New hi/lo values are visible from cycle L+1, and busy is low in cycle L+1.
- A back-to-back issue is accepted in cycle L+1 at the earliest.
- The edge that commits cannot also write MTHI/MTLO, because `running` is still 1 on that edge.
- Operands are sampled only at the issue edge. Changes to a/b afterwards have no effect.

## Test plan
- **Reset:** assert reset_n=0 mid-cycle with no clock edge → hi=lo=0 and busy=0 immediately.
- **MULT timing:** MULT a=0xFFFFFFFE (−2), b=3 → busy high for cycles 0–5, low in cycle 6; hi=0xFFFFFFFF, lo=0xFFFFFFFA in cycle 6. Repeat with MULTU → hi=0x00000002, lo=0xFFFFFFFA.
- **Signed division:** DIV a=−7, b=2 → busy through cycle 10; lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1). DIVU a=7, b=2 → lo=3, hi=1.
- **Divide by zero and overflow:** MTHI 0x1234, MTLO 0x5678, then DIV b=0 → after 10 cycles hi=0x1234, lo=0x5678. DIV 0x80000000 by −1 → lo=0x80000000, hi=0.
- **cancel and ignored requests:** MULT with cancel=1 → busy high only in that cycle, no state change. MTLO issued in cycle 2 of a running MULT → ignored; lo ends as the product.
- **Reset mid-divide:** pulse reset_n low in cycle 4 of a DIV → busy=0, hi=lo=0 immediately; no commit follows. A new MULT issued next is accepted normally.
